// File: rtl/bus_with_mux.sv
// Shared N-bit bus built from a 2:1 mux; two destination registers capture it each clock.
// Optional BUS_XFER_CNT_EN adds a free-running 16-bit transfer counter on port xfer_count.
module bus_with_mux #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] data_in_1,
  input  logic [N-1:0] data_in_2,
  input  logic         sel,
  output logic [N-1:0] bus,
  output logic [N-1:0] data_out_1,
  output logic [N-1:0] data_out_2
`ifdef BUS_XFER_CNT_EN
  ,
  output logic [15:0]  xfer_count
`endif
);

  logic [N-1:0] data_out_1_d, data_out_1_q;
  logic [N-1:0] data_out_2_d, data_out_2_q;

  // Bus owner drives, the opposite side's register captures it.
  always_comb begin
    bus          = sel ? data_in_2 : data_in_1;
    data_out_1_d = data_out_1_q;
    data_out_2_d = data_out_2_q;
    if (sel) data_out_1_d = bus;
    else     data_out_2_d = bus;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_1_q <= '0;
      data_out_2_q <= '0;
    end else begin
      data_out_1_q <= data_out_1_d;
      data_out_2_q <= data_out_2_d;
    end
  end

  assign data_out_1 = data_out_1_q;
  assign data_out_2 = data_out_2_q;

`ifdef BUS_XFER_CNT_EN
  logic [15:0] xfer_count_d, xfer_count_q;

  // Wraps naturally from FFFF to 0000.
  always_comb begin
    xfer_count_d = xfer_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) xfer_count_q <= '0;
    else     xfer_count_q <= xfer_count_d;
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_bus_with_mux.sv
// Directed self-checking bench for bus_with_mux; counter checks build only with BUS_XFER_CNT_EN.
module tb_bus_with_mux;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] data_in_1, data_in_2;
  logic         sel;
  logic [N-1:0] bus, data_out_1, data_out_2;
`ifdef BUS_XFER_CNT_EN
  logic [15:0]  xfer_count;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;

  bus_with_mux #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in_1  (data_in_1),
    .data_in_2  (data_in_2),
    .sel        (sel),
    .bus        (bus),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2)
`ifdef BUS_XFER_CNT_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; data_in_1 = '0; data_in_2 = '0;
    #2;
    check("rst_dout1_noclk", 16'(data_out_1), 16'h00);
    check("rst_dout2_noclk", 16'(data_out_2), 16'h00);
`ifdef BUS_XFER_CNT_EN
    check("rst_cnt_noclk", xfer_count, 16'h0000);
`endif
    // Registers stay cleared across edges while reset is held
    data_in_1 = 8'h11; data_in_2 = 8'h22;
    tick(); tick();
    check("rst_hold_dout1", 16'(data_out_1), 16'h00);
    check("rst_hold_dout2", 16'(data_out_2), 16'h00);
    check("rst_bus_live", 16'(bus), 16'h11);
    rst = 1'b0;

    sel = 1'b0; data_in_1 = 8'hA2; data_in_2 = 8'h9C;
    #1 check("bus_sel0", 16'(bus), 16'hA2);
    tick();
    check("x0_dout2", 16'(data_out_2), 16'hA2);
    check("x0_dout1_held", 16'(data_out_1), 16'h00);
`ifdef BUS_XFER_CNT_EN
    check("cnt_1", xfer_count, 16'd1);
`endif

    sel = 1'b1;
    #1 check("bus_sel1", 16'(bus), 16'h9C);
    check("sel_no_edge_dout1", 16'(data_out_1), 16'h00);
    tick();
    check("x1_dout1", 16'(data_out_1), 16'h9C);
    check("x1_dout2_held", 16'(data_out_2), 16'hA2);

    for (int i = 0; i < 4; i++) begin
      sel = (i % 2 == 1);
      #1 check("toggle_bus", 16'(bus), (i % 2 == 1) ? 16'h9C : 16'hA2);
      tick();
      check("toggle_dout1", 16'(data_out_1), 16'h9C);
      check("toggle_dout2", 16'(data_out_2), 16'hA2);
    end

    sel = 1'b1; data_in_1 = 8'h54; data_in_2 = 8'h90;
    #1 check("bus_90", 16'(bus), 16'h90);
    tick();
    check("d_dout1_90", 16'(data_out_1), 16'h90);
    check("d_dout2_held", 16'(data_out_2), 16'hA2);
    sel = 1'b0;
    #1 check("bus_54", 16'(bus), 16'h54);
    tick();
    check("d_dout2_54", 16'(data_out_2), 16'h54);
    check("d_dout1_held", 16'(data_out_1), 16'h90);
`ifdef BUS_XFER_CNT_EN
    check("cnt_8", xfer_count, 16'd8);
`endif

    // Mid-cycle reset while a capture of bus=54 into dout2 is pending
    #3 rst = 1'b1;
    #1 check("mid_rst_dout1", 16'(data_out_1), 16'h00);
    check("mid_rst_dout2", 16'(data_out_2), 16'h00);
    check("mid_rst_bus", 16'(bus), 16'h54);
`ifdef BUS_XFER_CNT_EN
    check("mid_rst_cnt", xfer_count, 16'h0000);
`endif
    tick();
    check("mid_rst_edge_dout2", 16'(data_out_2), 16'h00);
    rst = 1'b0; sel = 1'b0;
    tick();
    check("rel_dout2", 16'(data_out_2), 16'h54);
    check("rel_dout1", 16'(data_out_1), 16'h00);

    // Data change between edges only moves the bus
    data_in_1 = 8'h3C;
    #1 check("between_bus", 16'(bus), 16'h3C);
    check("between_dout2", 16'(data_out_2), 16'h54);
    tick();
    check("between_after_edge", 16'(data_out_2), 16'h3C);
`ifdef BUS_XFER_CNT_EN
    check("cnt_rel_2", xfer_count, 16'd2);
    repeat (65533) @(posedge clk);
    #1 check("cnt_ffff", xfer_count, 16'hFFFF);
    tick();
    check("cnt_wrap", xfer_count, 16'h0000);
    tick();
    check("cnt_after_wrap", xfer_count, 16'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
